memory_write_ctrl: RTL and testbench



---
 rtl/memory_write_ctrl_pkg.sv | 30 +++
 rtl/memory_write_ctrl_frame_desc_reg.sv | 33 +++
 rtl/memory_write_ctrl.sv | 117 +++++++++++
 tb/tb_memory_write_ctrl.sv | 392 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/memory_write_ctrl_pkg.sv
// Shared definitions for the block-linked frame buffer (write and read sides).
package memory_write_ctrl_pkg;

    localparam int unsigned ADDR_W     = 12;
    localparam int unsigned BLOCK_BITS = 512;
    localparam int unsigned FOOTER_W   = 16;
    localparam int unsigned PAYLOAD_W  = BLOCK_BITS - FOOTER_W;

    // Link footer stored in the low 16 bits of every block.
    typedef struct packed {
        logic [ADDR_W-1:0] next_idx;
        logic              eop;
        logic [2:0]        rsvd;
    } footer_t;

    typedef enum logic {
        ALLOC  = 1'b0,
        STREAM = 1'b1
    } wr_state_t;

    function automatic footer_t make_footer(input logic [ADDR_W-1:0] next_idx,
                                            input logic eop);
        footer_t f;
        f.next_idx = next_idx;
        f.eop      = eop;
        f.rsvd     = '0;
        return f;
    endfunction

endpackage

// File: rtl/memory_write_ctrl_frame_desc_reg.sv
// One-entry frame descriptor holding register with valid/ready handshake.
module frame_desc_reg
    import memory_write_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_start,
    input  logic [CNT_W-1:0]  load_nblocks,
    output logic              valid,
    input  logic              ready,
    output logic [ADDR_W-1:0] start_addr,
    output logic [CNT_W-1:0]  nblocks
);

    // Capture a descriptor on load; drop valid the cycle after the handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid      <= 1'b0;
            start_addr <= '0;
            nblocks    <= '0;
        end else if (load) begin
            valid      <= 1'b1;
            start_addr <= load_start;
            nblocks    <= load_nblocks;
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/memory_write_ctrl.sv
// Write side of the block-linked frame buffer: links payload blocks through
// free-list indices and emits a {start, count} descriptor per frame.
module memory_write_ctrl
    import memory_write_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [PAYLOAD_W-1:0]  data_i,
    input  logic                  data_valid_i,
    input  logic                  data_end_i,
    output logic                  data_ready_o,
    input  logic                  free_valid_i,
    input  logic [ADDR_W-1:0]     free_idx_i,
    output logic                  free_pop_o,
    output logic                  mem_we_o,
    output logic [ADDR_W-1:0]     mem_waddr_o,
    output logic [BLOCK_BITS-1:0] mem_wdata_o,
    output logic                  desc_valid_o,
    input  logic                  desc_ready_i,
    output logic [ADDR_W-1:0]     desc_start_addr_o,
    output logic [CNT_W-1:0]      desc_nblocks_o
);

    wr_state_t         state;
    logic [ADDR_W-1:0] cur_addr;
    logic              cur_valid;
    logic              in_frame;
    logic [ADDR_W-1:0] frame_start;
    logic [CNT_W-1:0]  blk_cnt;

    logic              accept;
    logic              accept_end;
    logic [CNT_W-1:0]  cnt_next;
    logic [ADDR_W-1:0] start_next;

    // Handshake decode; a spare free index is required even for the end block
    // so that readiness never depends on data_end_i.
    always_comb begin
        data_ready_o = rst_n && (state == STREAM) && cur_valid
                       && free_valid_i && !desc_valid_o;
        accept       = data_valid_i && data_ready_o;
        accept_end   = accept && data_end_i;
        if (state == ALLOC)
            free_pop_o = rst_n && free_valid_i;
        else
            free_pop_o = accept && !data_end_i;
        if (!in_frame)
            cnt_next = CNT_W'(1);
        else if (&blk_cnt)
            cnt_next = blk_cnt;
        else
            cnt_next = blk_cnt + CNT_W'(1);
        start_next = in_frame ? frame_start : cur_addr;
    end

    // Block allocation / streaming FSM with registered memory write port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ALLOC;
            cur_addr    <= '0;
            cur_valid   <= 1'b0;
            in_frame    <= 1'b0;
            frame_start <= '0;
            blk_cnt     <= '0;
            mem_we_o    <= 1'b0;
            mem_waddr_o <= '0;
            mem_wdata_o <= '0;
        end else begin
            mem_we_o <= 1'b0;
            case (state)
                ALLOC: begin
                    if (free_valid_i) begin
                        cur_addr  <= free_idx_i;
                        cur_valid <= 1'b1;
                        state     <= STREAM;
                    end
                end
                STREAM: begin
                    if (accept) begin
                        mem_we_o    <= 1'b1;
                        mem_waddr_o <= cur_addr;
                        blk_cnt     <= cnt_next;
                        frame_start <= start_next;
                        if (data_end_i) begin
                            mem_wdata_o <= {data_i, make_footer('0, 1'b1)};
                            cur_valid   <= 1'b0;
                            in_frame    <= 1'b0;
                            state       <= ALLOC;
                        end else begin
                            mem_wdata_o <= {data_i, make_footer(free_idx_i, 1'b0)};
                            cur_addr    <= free_idx_i;
                            in_frame    <= 1'b1;
                        end
                    end
                end
                default: state <= ALLOC;
            endcase
        end
    end

    frame_desc_reg #(
        .CNT_W(CNT_W)
    ) u_desc (
        .clk          (clk),
        .rst_n        (rst_n),
        .load         (accept_end),
        .load_start   (start_next),
        .load_nblocks (cnt_next),
        .valid        (desc_valid_o),
        .ready        (desc_ready_i),
        .start_addr   (desc_start_addr_o),
        .nblocks      (desc_nblocks_o)
    );

endmodule

// File: tb/tb_memory_write_ctrl.sv
// Directed bench for memory_write_ctrl: FWFT free-list model, write/descriptor logs.
module tb_memory_write_ctrl;
    import memory_write_ctrl_pkg::*;

    localparam int unsigned CNT_W = 8;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [PAYLOAD_W-1:0]  data_i;
    logic                  data_valid_i;
    logic                  data_end_i;
    logic                  data_ready_o;
    logic                  free_valid_i;
    logic [ADDR_W-1:0]     free_idx_i;
    logic                  free_pop_o;
    logic                  mem_we_o;
    logic [ADDR_W-1:0]     mem_waddr_o;
    logic [BLOCK_BITS-1:0] mem_wdata_o;
    logic                  desc_valid_o;
    logic                  desc_ready_i;
    logic [ADDR_W-1:0]     desc_start_addr_o;
    logic [CNT_W-1:0]      desc_nblocks_o;

    always #5 clk = ~clk;

    memory_write_ctrl #(.CNT_W(CNT_W)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .data_i            (data_i),
        .data_valid_i      (data_valid_i),
        .data_end_i        (data_end_i),
        .data_ready_o      (data_ready_o),
        .free_valid_i      (free_valid_i),
        .free_idx_i        (free_idx_i),
        .free_pop_o        (free_pop_o),
        .mem_we_o          (mem_we_o),
        .mem_waddr_o       (mem_waddr_o),
        .mem_wdata_o       (mem_wdata_o),
        .desc_valid_o      (desc_valid_o),
        .desc_ready_i      (desc_ready_i),
        .desc_start_addr_o (desc_start_addr_o),
        .desc_nblocks_o    (desc_nblocks_o)
    );

    typedef struct {
        int unsigned addr;
        int unsigned nxt;
        bit          eop;
        int unsigned tag;
    } wr_t;

    typedef struct {
        int unsigned start;
        int unsigned nb;
    } desc_t;

    // One directed vector: inputs (tag, last) and the expected write.
    typedef struct {
        int unsigned tag;
        bit          last;
        int unsigned addr;
        int unsigned nxt;
        bit          eop;
    } vec_t;

    vec_t        tab[10];
    wr_t         wlog[$];
    desc_t       dlog[$];
    int unsigned fl[$];
    int unsigned pops[$];
    bit          gap;
    bit          acc_s;
    bit          rdy_s;
    int          checks = 0;
    int          errors = 0;
    int          bad_rsvd = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic drive_free();
        free_valid_i = (fl.size() > 0) && !gap;
        free_idx_i   = (fl.size() > 0) ? ADDR_W'(fl[0]) : '0;
    endtask

    // Called at a negedge with inputs set; returns at the next negedge.
    task automatic cycle();
        bit      pop_s;
        bit      hs;
        footer_t f;
        wr_t     w;
        desc_t   d;
        #1;
        pop_s = free_pop_o;
        rdy_s = data_ready_o;
        acc_s = data_valid_i && data_ready_o;
        hs    = desc_valid_o && desc_ready_i;
        if (hs) begin
            d.start = int'(desc_start_addr_o);
            d.nb    = int'(desc_nblocks_o);
            dlog.push_back(d);
        end
        @(posedge clk);
        #1;
        if (pop_s && fl.size() > 0) begin
            pops.push_back(fl[0]);
            void'(fl.pop_front());
        end
        drive_free();
        @(negedge clk);
        if (mem_we_o) begin
            f      = footer_t'(mem_wdata_o[FOOTER_W-1:0]);
            w.addr = int'(mem_waddr_o);
            w.nxt  = int'(f.next_idx);
            w.eop  = f.eop;
            w.tag  = mem_wdata_o[47:16];
            if (f.rsvd != 3'd0) bad_rsvd++;
            wlog.push_back(w);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) cycle();
    endtask

    task automatic send_block(input int unsigned tag, input bit last);
        int cnt;
        data_i        = '0;
        data_i[31:0]  = tag;
        data_valid_i  = 1'b1;
        data_end_i    = last;
        cnt = 0;
        do begin
            cycle();
            cnt++;
        end while (!acc_s && cnt < 60);
        if (!acc_s) chk("accept_timeout", 64'(tag), 64'hFFFF_FFFF);
        data_valid_i = 1'b0;
        data_end_i   = 1'b0;
    endtask

    task automatic send_frame(input int n, input int unsigned tagbase);
        for (int k = 0; k < n; k++) send_block(tagbase + k, k == n - 1);
    endtask

    task automatic chk_zero(input string tagname);
        chk({tagname, "_ready"}, data_ready_o, 0);
        chk({tagname, "_pop"}, free_pop_o, 0);
        chk({tagname, "_we"}, mem_we_o, 0);
        chk({tagname, "_waddr"}, mem_waddr_o, 0);
        chk({tagname, "_wdata_nz"}, |mem_wdata_o, 0);
        chk({tagname, "_dvalid"}, desc_valid_o, 0);
        chk({tagname, "_dstart"}, desc_start_addr_o, 0);
        chk({tagname, "_dnb"}, desc_nblocks_o, 0);
    endtask

    task automatic do_reset(input bit keep_fl);
        data_valid_i = 1'b0;
        data_end_i   = 1'b0;
        desc_ready_i = 1'b1;
        gap          = 1'b0;
        if (!keep_fl) fl.delete();
        drive_free();
        rst_n = 1'b0;
        #1;
        chk_zero("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wlog.delete();
        dlog.delete();
        pops.delete();
    endtask

    task automatic apply_vec(input int i);
        send_block(tab[i].tag, tab[i].last);
    endtask

    task automatic check_writes(input string name, input int first, input int count);
        chk({name, "_nwrites"}, wlog.size(), count);
        for (int i = 0; i < count && i < wlog.size(); i++) begin
            chk({name, "_addr"}, wlog[i].addr, tab[first+i].addr);
            chk({name, "_next"}, wlog[i].nxt, tab[first+i].nxt);
            chk({name, "_eop"}, wlog[i].eop, tab[first+i].eop);
            chk({name, "_payload"}, wlog[i].tag, tab[first+i].tag);
        end
    endtask

    task automatic check_pops(input string name, input int unsigned base, input int n);
        chk({name, "_npops"}, pops.size(), n);
        for (int i = 0; i < n && i < pops.size(); i++)
            chk({name, "_pop"}, pops[i], base + i);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        int bad;
        // {tag, last, addr, next, eop}
        tab[0] = '{100, 1'b0,  5,  9, 1'b0};
        tab[1] = '{101, 1'b0,  9,  2, 1'b0};
        tab[2] = '{102, 1'b1,  2,  0, 1'b1};
        tab[3] = '{200, 1'b1,  7,  0, 1'b1};
        tab[4] = '{300, 1'b0, 20, 21, 1'b0};
        tab[5] = '{301, 1'b0, 21, 22, 1'b0};
        tab[6] = '{302, 1'b0, 22, 23, 1'b0};
        tab[7] = '{303, 1'b0, 23, 24, 1'b0};
        tab[8] = '{304, 1'b0, 24, 25, 1'b0};
        tab[9] = '{305, 1'b1, 25,  0, 1'b1};

        rst_n        = 1'b1;
        data_i       = '0;
        data_valid_i = 1'b0;
        data_end_i   = 1'b0;
        desc_ready_i = 1'b1;
        gap          = 1'b0;
        drive_free();
        #2;

        // 3-block frame from free list 5,9,2 (+11 prefetched)
        do_reset(1'b0);
        fl = '{5, 9, 2, 11};
        drive_free();
        for (int i = 0; i < 3; i++) apply_vec(i);
        idle(4);
        check_writes("f3", 0, 3);
        chk("f3_ndesc", dlog.size(), 1);
        if (dlog.size() > 0) begin
            chk("f3_dstart", dlog[0].start, 5);
            chk("f3_dnb", dlog[0].nb, 3);
        end
        chk("f3_npops", pops.size(), 4);
        if (pops.size() == 4) begin
            chk("f3_pop0", pops[0], 5);
            chk("f3_pop1", pops[1], 9);
            chk("f3_pop2", pops[2], 2);
            chk("f3_pop3", pops[3], 11);
        end

        // Single-block frame, 8 prefetched afterwards
        do_reset(1'b0);
        fl = '{7, 8};
        drive_free();
        apply_vec(3);
        idle(4);
        check_writes("f1", 3, 1);
        chk("f1_ndesc", dlog.size(), 1);
        if (dlog.size() > 0) begin
            chk("f1_dstart", dlog[0].start, 7);
            chk("f1_dnb", dlog[0].nb, 1);
        end
        check_pops("f1", 7, 2);

        // free_valid_i dropped 4 cycles mid-frame
        do_reset(1'b0);
        for (int i = 20; i <= 26; i++) fl.push_back(i);
        drive_free();
        apply_vec(4);
        apply_vec(5);
        n0  = wlog.size();
        gap = 1'b1;
        drive_free();
        data_i       = '0;
        data_i[31:0] = tab[6].tag;
        data_valid_i = 1'b1;
        bad = 0;
        repeat (4) begin
            cycle();
            if (rdy_s || acc_s) bad++;
        end
        chk("gap_ready_low", bad, 0);
        chk("gap_no_write", wlog.size(), n0);
        gap = 1'b0;
        drive_free();
        for (int i = 6; i < 10; i++) apply_vec(i);
        idle(4);
        check_writes("gap", 4, 6);
        chk("gap_ndesc", dlog.size(), 1);
        if (dlog.size() > 0) begin
            chk("gap_dstart", dlog[0].start, 20);
            chk("gap_dnb", dlog[0].nb, 6);
        end
        check_pops("gap", 20, 7);

        // Descriptor back-pressure with a second frame waiting
        do_reset(1'b0);
        for (int i = 40; i <= 45; i++) fl.push_back(i);
        drive_free();
        desc_ready_i = 1'b0;
        send_frame(2, 400);
        data_i       = '0;
        data_i[31:0] = 500;
        data_valid_i = 1'b1;
        bad = 0;
        repeat (10) begin
            cycle();
            if (rdy_s || acc_s) bad++;
            if (desc_valid_o !== 1'b1 || desc_start_addr_o !== ADDR_W'(40)
                || desc_nblocks_o !== CNT_W'(2)) bad++;
        end
        chk("hold_stall_stable", bad, 0);
        chk("hold_nwrites", wlog.size(), 2);
        desc_ready_i = 1'b1;
        send_frame(2, 500);
        idle(4);
        chk("hold_dvalid_clear", desc_valid_o, 0);
        chk("hold_ndesc", dlog.size(), 2);
        if (dlog.size() == 2) begin
            chk("hold_d0_start", dlog[0].start, 40);
            chk("hold_d0_nb", dlog[0].nb, 2);
            chk("hold_d1_start", dlog[1].start, 42);
            chk("hold_d1_nb", dlog[1].nb, 2);
        end
        chk("hold_nwrites_end", wlog.size(), 4);
        if (wlog.size() == 4) begin
            chk("hold_w0", {wlog[0].addr, wlog[0].nxt}, {32'd40, 32'd41});
            chk("hold_w1", {wlog[1].addr, wlog[1].nxt}, {32'd41, 32'd0});
            chk("hold_w1_eop", wlog[1].eop, 1);
            chk("hold_w2", {wlog[2].addr, wlog[2].nxt}, {32'd42, 32'd43});
            chk("hold_w3", {wlog[3].addr, wlog[3].nxt}, {32'd43, 32'd0});
            chk("hold_w3_tag", wlog[3].tag, 501);
        end
        check_pops("hold", 40, 5);

        // 300-block frame: counter saturates at 255
        do_reset(1'b0);
        for (int i = 100; i <= 400; i++) fl.push_back(i);
        drive_free();
        send_frame(300, 1000);
        idle(4);
        chk("big_nwrites", wlog.size(), 300);
        bad = 0;
        for (int i = 0; i < 300 && i < wlog.size(); i++) begin
            if (wlog[i].addr != 100 + i) bad++;
            if (wlog[i].nxt != ((i < 299) ? 101 + i : 0)) bad++;
            if (wlog[i].eop != (i == 299)) bad++;
            if (wlog[i].tag != 1000 + i) bad++;
        end
        chk("big_chain_bad", bad, 0);
        chk("big_ndesc", dlog.size(), 1);
        if (dlog.size() > 0) begin
            chk("big_dstart", dlog[0].start, 100);
            chk("big_dnb_sat", dlog[0].nb, 255);
        end

        // Reset mid-frame after 2 blocks
        do_reset(1'b0);
        for (int i = 60; i <= 70; i++) fl.push_back(i);
        drive_free();
        send_block(600, 1'b0);
        send_block(601, 1'b0);
        chk("mid_nwrites", wlog.size(), 2);
        #2;
        rst_n = 1'b0;
        #1;
        chk_zero("midrst");
        repeat (2) @(negedge clk);
        chk("midrst_ndesc", dlog.size(), 0);
        rst_n = 1'b1;
        wlog.delete();
        dlog.delete();
        pops.delete();
        send_frame(1, 700);
        idle(4);
        chk("post_nwrites", wlog.size(), 1);
        if (wlog.size() > 0) begin
            chk("post_addr", wlog[0].addr, 63);
            chk("post_next", wlog[0].nxt, 0);
            chk("post_eop", wlog[0].eop, 1);
        end
        chk("post_ndesc", dlog.size(), 1);
        if (dlog.size() > 0) begin
            chk("post_dstart", dlog[0].start, 63);
            chk("post_dnb", dlog[0].nb, 1);
        end

        chk("rsvd_zero", bad_rsvd, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
